// File: rtl/cnn_pkg.sv
// Shared types and default constants for the convolution tile engine.
// Holds the FSM encoding used by conv_tile_engine.
package cnn_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_WRITE
  } state_t;

  localparam int DATA_W_D    = 16;
  localparam int ACC_W_D     = 32;
  localparam int K_D         = 3;
  localparam int TILE_D      = 2;
  localparam int STRIDE_D    = 3;
  localparam int NUM_FILT_D  = 4;
  localparam int COORD_W_D   = 4;
  localparam int OUT_SHIFT_D = 16;
  localparam int OUT_AW_D    = 8;

endpackage

// File: rtl/conv_mac_unit.sv
// Signed multiply-accumulate with shift, ReLU and saturation
// postprocessing for one convolution window.
module conv_mac_unit
  import cnn_pkg::*;
#(
  parameter int DATA_W    = DATA_W_D,
  parameter int ACC_W     = ACC_W_D,
  parameter int OUT_SHIFT = OUT_SHIFT_D
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic signed [DATA_W-1:0] wt_data,
  input  logic                     relu_en,
  input  logic                     sat_en,
  output logic        [DATA_W-1:0] result
);

  localparam logic signed [ACC_W-1:0] SMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    acc;
  logic signed [ACC_W-1:0]    s;

  assign prod = in_data * wt_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (valid) begin
      acc <= acc + ACC_W'(prod);
    end
  end

  always_comb begin
    s = acc >>> OUT_SHIFT;
    if (relu_en && s < 0) begin
      s = '0;
    end
    if (sat_en) begin
      if (s > SMAX) begin
        s = SMAX;
      end else if (s < SMIN) begin
        s = SMIN;
      end
    end
    result = s[DATA_W-1:0];
  end

endmodule

// File: rtl/conv_tile_engine.sv
// Tile-level convolution sequencer: walks filters, output windows
// and kernel taps, and writes one postprocessed result per window.
module conv_tile_engine
  import cnn_pkg::*;
#(
  parameter int DATA_W    = DATA_W_D,
  parameter int ACC_W     = ACC_W_D,
  parameter int K         = K_D,
  parameter int TILE      = TILE_D,
  parameter int STRIDE    = STRIDE_D,
  parameter int NUM_FILT  = NUM_FILT_D,
  parameter int COORD_W   = COORD_W_D,
  parameter int OUT_SHIFT = OUT_SHIFT_D,
  parameter int OUT_AW    = OUT_AW_D
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [COORD_W-1:0]   origin_x,
  input  logic [COORD_W-1:0]   origin_y,
  input  logic [OUT_AW-1:0]    out_base,
  input  logic                 relu_en,
  input  logic                 sat_en,
  output logic                 busy,
  output logic                 done,
  output logic [2*COORD_W-1:0] in_addr,
  input  logic [DATA_W-1:0]    in_data,
  output logic [$clog2(NUM_FILT)+$clog2(K*K)-1:0] wt_addr,
  input  logic [DATA_W-1:0]    wt_data,
  output logic                 wr_en,
  output logic [OUT_AW-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data
);

  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int TW  = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int FW  = $clog2(NUM_FILT);
  localparam int KKW = $clog2(K*K);

  state_t state, state_n;

  logic [KW-1:0]      kx, ky;
  logic [TW-1:0]      tx, ty;
  logic [FW-1:0]      filt;
  logic [COORD_W-1:0] ox, oy;
  logic [OUT_AW-1:0]  base;
  logic               relu_q, sat_q;
  logic               fetch_d;
  logic               accept;
  logic               last_tap;
  logic               last_win;
  logic [COORD_W-1:0] ax, ay;
  logic [DATA_W-1:0]  result;

  assign accept   = start && !busy;
  assign last_tap = (kx == KW'(K-1)) && (ky == KW'(K-1));
  assign last_win = (tx == TW'(TILE-1)) && (ty == TW'(TILE-1)) &&
                    (filt == FW'(NUM_FILT-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      fetch_d <= 1'b0;
    end else begin
      state   <= state_n;
      done    <= (state == S_WRITE) && last_win;
      fetch_d <= (state == S_FETCH);
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (accept) state_n = S_FETCH;
      S_FETCH: if (last_tap) state_n = S_DRAIN;
      S_DRAIN: state_n = S_WRITE;
      S_WRITE: state_n = last_win ? S_IDLE : S_FETCH;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ox     <= '0;
      oy     <= '0;
      base   <= '0;
      relu_q <= 1'b0;
      sat_q  <= 1'b0;
    end else if (accept) begin
      ox     <= origin_x;
      oy     <= origin_y;
      base   <= out_base;
      relu_q <= relu_en;
      sat_q  <= sat_en;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kx   <= '0;
      ky   <= '0;
      tx   <= '0;
      ty   <= '0;
      filt <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            kx   <= '0;
            ky   <= '0;
            tx   <= '0;
            ty   <= '0;
            filt <= '0;
          end
        end
        S_FETCH: begin
          if (kx == KW'(K-1)) begin
            kx <= '0;
            ky <= (ky == KW'(K-1)) ? '0 : ky + 1'b1;
          end else begin
            kx <= kx + 1'b1;
          end
        end
        S_WRITE: begin
          if (tx == TW'(TILE-1)) begin
            tx <= '0;
            if (ty == TW'(TILE-1)) begin
              ty   <= '0;
              filt <= (filt == FW'(NUM_FILT-1)) ? '0 : filt + 1'b1;
            end else begin
              ty <= ty + 1'b1;
            end
          end else begin
            tx <= tx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ax = ox + COORD_W'(tx * STRIDE) + COORD_W'(kx);
  assign ay = oy + COORD_W'(ty * STRIDE) + COORD_W'(ky);

  always_comb begin
    busy    = (state != S_IDLE) || done;
    in_addr = '0;
    wt_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (state == S_FETCH) begin
      in_addr = {ay, ax};
      wt_addr = {filt, KKW'(ky * K + kx)};
    end
    if (state == S_WRITE) begin
      wr_en   = 1'b1;
      wr_addr = base + OUT_AW'(filt * TILE * TILE + ty * TILE + tx);
      wr_data = result;
    end
  end

  // Data for tap n arrives with tap n+1's address, so the first
  // tap of a window clears while nothing is valid yet.
  conv_mac_unit #(
    .DATA_W    (DATA_W),
    .ACC_W     (ACC_W),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_mac (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state == S_FETCH) && (kx == '0) && (ky == '0)),
    .valid   (fetch_d),
    .in_data (in_data),
    .wt_data (wt_data),
    .relu_en (relu_q),
    .sat_en  (sat_q),
    .result  (result)
  );

endmodule

// File: tb/tb_conv_tile_engine.sv
// Directed bench for conv_tile_engine: defaults, ReLU, saturation,
// addressing, ignored start and mid-tile reset.
module tb_conv_tile_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  origin_x = '0;
  logic [3:0]  origin_y = '0;
  logic [7:0]  out_base = '0;
  logic        relu_en = 1'b0;
  logic        sat_en = 1'b0;
  logic [15:0] in_data = 16'h0100;
  logic [15:0] wt_data = 16'h0100;

  logic        busy, done, wr_en;
  logic [7:0]  in_addr, wr_addr;
  logic [5:0]  wt_addr;
  logic [15:0] wr_data;

  logic        busy_b, done_b, wr_en_b;
  logic [7:0]  in_addr_b, wr_addr_b;
  logic [5:0]  wt_addr_b;
  logic [15:0] wr_data_b;

  conv_tile_engine dut (
    .clk(clk), .reset(reset), .start(start),
    .origin_x(origin_x), .origin_y(origin_y),
    .out_base(out_base), .relu_en(relu_en), .sat_en(sat_en),
    .busy(busy), .done(done), .in_addr(in_addr),
    .in_data(in_data), .wt_addr(wt_addr), .wt_data(wt_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  conv_tile_engine #(.OUT_SHIFT(8)) dut_s8 (
    .clk(clk), .reset(reset), .start(start),
    .origin_x(origin_x), .origin_y(origin_y),
    .out_base(out_base), .relu_en(relu_en), .sat_en(sat_en),
    .busy(busy_b), .done(done_b), .in_addr(in_addr_b),
    .in_data(in_data), .wt_addr(wt_addr_b), .wt_data(wt_data),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nw = 0;
  int nd = 0;
  int dcyc = 0;
  int wa [256];
  int wd [256];
  int wc [256];
  logic [15:0] bd = '0;

  always @(negedge clk) begin
    if (wr_en && nw < 256) begin
      wa[nw] = int'(wr_addr);
      wd[nw] = int'(wr_data);
      wc[nw] = cyc;
      nw = nw + 1;
    end
    if (done) begin
      nd = nd + 1;
      dcyc = cyc;
    end
    if (wr_en_b) bd = wr_data_b;
  end

  int passed = 0;
  int total = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(input logic [3:0] ox, input logic [3:0] oy,
                    input logic [7:0] b, input logic r,
                    input logic s, output int c0);
    origin_x = ox;
    origin_y = oy;
    out_base = b;
    relu_en  = r;
    sat_en   = s;
    start    = 1'b1;
    c0       = cyc;
    tick();
    start    = 1'b0;
    origin_x = 4'hF;
    origin_y = 4'hF;
    out_base = 8'hEE;
    relu_en  = ~r;
    sat_en   = ~s;
  endtask

  task automatic wait_done(input int nd0);
    int n = 0;
    while (nd == nd0 && n < 400) begin
      tick();
      n++;
    end
    if (nd == nd0) chk("done_timeout", 0, 1);
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int c0, nw0, nd0, nw1;

  initial begin
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_in_addr", in_addr, 0);
    chk("rst_wt_addr", wt_addr, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    reset = 1'b1;
    tick();

    // defaults, with an extra start pulsed at cycle 20
    nw0 = nw; nd0 = nd;
    go(4'd0, 4'd0, 8'h00, 1'b0, 1'b0, c0);
    chk("c1_busy", busy, 1);
    chk("c1_in_addr", in_addr, 8'h00);
    chk("c1_wt_addr", wt_addr, 6'h00);
    while (cyc < c0 + 20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(nd0);
    chk("def_count", nw - nw0, 16);
    chk("def_done_cyc", dcyc - c0, 177);
    chk("def_done_once", nd - nd0, 1);
    chk("def_first_wr_cyc", wc[nw0] - c0, 11);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("def_addr%0d", i), wa[nw0+i], i);
      chk($sformatf("def_data%0d", i), wd[nw0+i], 16'h0009);
    end
    chk("def_s8_data", bd, 16'h0900);
    chk("def_idle_busy", busy, 0);
    chk("def_idle_done", done, 0);
    chk("def_idle_wr_data", wr_data, 0);

    // negative products with and without ReLU
    in_data = 16'h0100;
    wt_data = 16'hFF00;
    nw0 = nw; nd0 = nd;
    go(4'd0, 4'd0, 8'h00, 1'b1, 1'b0, c0);
    wait_done(nd0);
    chk("relu_on_first", wd[nw0], 16'h0000);
    chk("relu_on_last", wd[nw0+15], 16'h0000);
    nw0 = nw; nd0 = nd;
    go(4'd0, 4'd0, 8'h00, 1'b0, 1'b0, c0);
    wait_done(nd0);
    chk("relu_off_first", wd[nw0], 16'hFFF7);
    chk("relu_off_last", wd[nw0+15], 16'hFFF7);

    // saturation on the OUT_SHIFT=8 instance
    in_data = 16'h1000;
    wt_data = 16'h0100;
    nw0 = nw; nd0 = nd;
    go(4'd0, 4'd0, 8'h00, 1'b0, 1'b1, c0);
    wait_done(nd0);
    chk("sat_on_s8", bd, 16'h7FFF);
    chk("sat_on_s16", wd[nw0], 16'h0090);
    nw0 = nw; nd0 = nd;
    go(4'd0, 4'd0, 8'h00, 1'b0, 1'b0, c0);
    wait_done(nd0);
    chk("sat_off_s8", bd, 16'h9000);

    // addressing with origin x=6, y=0 and base 0x20
    in_data = 16'h0100;
    nw0 = nw; nd0 = nd;
    go(4'd6, 4'd0, 8'h20, 1'b0, 1'b0, c0);
    chk("org_first_in_addr", in_addr, 8'h06);
    while (cyc < c0 + 122) tick();
    chk("win11_in_addr", in_addr, 8'h39);
    chk("win11_wt_addr", wt_addr, 6'h20);
    tick();
    chk("win11_in_addr_kx1", in_addr, 8'h3A);
    chk("win11_wt_addr_kx1", wt_addr, 6'h21);
    while (cyc < c0 + 132) tick();
    chk("win11_wr_en", wr_en, 1);
    chk("win11_wr_addr", wr_addr, 8'h2B);
    wait_done(nd0);
    chk("org_addr11", wa[nw0+11], 8'h2B);
    chk("org_addr15", wa[nw0+15], 8'h2F);

    // reset at cycle 50 abandons the tile
    nw0 = nw; nd0 = nd;
    go(4'd0, 4'd0, 8'h40, 1'b0, 1'b0, c0);
    while (cyc < c0 + 50) tick();
    chk("pre_rst_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_in_addr", in_addr, 0);
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    chk("mid_rst_writes", nw - nw0, 4);
    chk("mid_rst_no_done", nd - nd0, 0);
    nw1 = nw; nd0 = nd;
    go(4'd0, 4'd0, 8'h40, 1'b0, 1'b0, c0);
    wait_done(nd0);
    chk("restart_count", nw - nw1, 16);
    chk("restart_addr0", wa[nw1], 8'h40);
    chk("restart_wr_cyc", wc[nw1] - c0, 11);
    chk("restart_data0", wd[nw1], 16'h0009);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/conv_tile_engine.md
CONV_TILE_ENGINE -- requirements
Module: conv_tile_engine

Interface
REQ-001 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameters (name, default, meaning) SHALL be:
- DATA_W, 16, pixel/weight/output width, signed.
- ACC_W, 32, accumulator width.
- K, 3, kernel edge.
- TILE, 2, outputs per tile edge.
- STRIDE, 3, window step.
- NUM_FILT, 4, filters per tile.
- COORD_W, 4, coordinate width.
- OUT_SHIFT, 16, arithmetic right shift applied before output.
- OUT_AW, 8, output address width.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle tile request.
- origin_x, in, COORD_W, tile input x origin.
- origin_y, in, COORD_W, tile input y origin.
- out_base, in, OUT_AW, first output address.
- relu_en, in, 1, clamp negatives to 0.
- sat_en, in, 1, saturate to signed DATA_W.
- busy, out, 1, tile in progress.
- done, out, 1, one-cycle completion pulse.
- in_addr, out, 2*COORD_W, {y,x} input read address.
- in_data, in, DATA_W, input data, valid 1 cycle after in_addr.
- wt_addr, out, clog2(NUM_FILT)+clog2(K*K), {filter,ky*K+kx}.
- wt_data, in, DATA_W, weight data, valid 1 cycle after wt_addr.
- wr_en, out, 1, output write strobe.
- wr_addr, out, OUT_AW, output address.
- wr_data, out, DATA_W, output value.

Function
REQ-004 start SHALL be accepted only when busy=0; origin_x, origin_y, out_base, relu_en and sat_en SHALL be latched on acceptance; start while busy=1 SHALL be ignored.
REQ-005 FSM states SHALL be IDLE, FETCH, DRAIN, WRITE.
- IDLE->FETCH on accepted start.
- FETCH->DRAIN after K*K read cycles.
- DRAIN->WRITE after 1 cycle.
- WRITE->FETCH if windows remain, else ->IDLE with done=1 for that cycle.
REQ-006 Loop order SHALL be filter (outer), ty, tx, ky, kx (inner); total windows = NUM_FILT*TILE*TILE.
REQ-007 In FETCH, in_addr SHALL be {origin_y+ty*STRIDE+ky, origin_x+tx*STRIDE+kx}, truncated to COORD_W per field; wt_addr SHALL be {filter, ky*K+kx}; one address pair per cycle.
REQ-008 The accumulator SHALL clear on the first FETCH cycle of each window and add signed in_data*wt_data one cycle after each address, wrapping modulo 2^ACC_W.
REQ-009 Postprocessing SHALL proceed in this order:
- s = acc >>> OUT_SHIFT.
- If relu_en and s<0, then s=0.
- If sat_en, clamp s to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- wr_data = s[DATA_W-1:0].
REQ-010 In WRITE, wr_en SHALL be 1 for exactly one cycle with wr_addr = out_base + filter*TILE*TILE + ty*TILE + tx, modulo 2^OUT_AW.
REQ-011 Each window SHALL take K*K+2 cycles; the first read SHALL occur the cycle after start; done SHALL coincide with the final WRITE cycle + 1 (default: start at cycle 0, done at cycle 177).
REQ-012 busy SHALL be 1 from the cycle after acceptance through the done cycle inclusive; a start coincident with done SHALL be ignored.
REQ-013 When not in WRITE, wr_en SHALL be 0 and wr_addr and wr_data SHALL hold 0.

Reset
REQ-014 reset=0 SHALL asynchronously force IDLE: busy=0, done=0, wr_en=0, in_addr=0, wt_addr=0, wr_addr=0, wr_data=0, accumulator=0, all counters=0.
REQ-015 A reset mid-tile SHALL abandon the tile with no further writes; the next accepted start SHALL begin at filter 0, window (0,0).

Structure
REQ-016 The FSM state encoding and the default parameter constants SHALL reside in the shared package cnn_pkg.
REQ-017 The multiply-accumulate and postprocess datapath (REQ-008, REQ-009) SHALL be the sub-module conv_mac_unit; the counters and FSM SHALL stay in conv_tile_engine.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Defaults; all in_data=16'h0100, all wt_data=16'h0100, out_base=0 -> 16 writes, addresses 0..15, wr_data=16'h0009, done at cycle 177.
- wt_data=16'hFF00, in_data=16'h0100 -> relu_en=1 gives 16'h0000; relu_en=0 gives 16'hFFF7.
- OUT_SHIFT=8, in_data=16'h1000, wt_data=16'h0100 -> sat_en=1 gives 16'h7FFF; sat_en=0 gives 16'h9000.
- origin=(6,0), out_base=8'h20, filter 2, window (1,1) -> first in_addr=8'h39, wt_addr={2,0}, wr_addr=8'h2B.
- start pulsed at cycle 20 while busy -> ignored, write count stays 16; reset=0 at cycle 50 -> busy=0 and wr_en=0 immediately; a new start gives the first write at wr_addr=out_base.
